// File: rtl/queue_people_counter_if.sv
// Bus bundle for the queue people counter: raw photocell inputs in,
// occupancy count, flags and one-cycle event/error pulses out.
interface queue_people_counter_if #(
    parameter int CNT_W = 3
);
    logic             back_sensor;
    logic             front_sensor;
    logic [CNT_W-1:0] Pcount;
    logic             full;
    logic             empty;
    logic             enter_evt;
    logic             leave_evt;
    logic             overflow_err;
    logic             underflow_err;

    // Sensor side (drives the photocells, observes the counter)
    modport master (
        output back_sensor, front_sensor,
        input  Pcount, full, empty, enter_evt, leave_evt, overflow_err, underflow_err
    );

    // Counter side
    modport slave (
        input  back_sensor, front_sensor,
        output Pcount, full, empty, enter_evt, leave_evt, overflow_err, underflow_err
    );
endinterface

// File: rtl/queue_people_counter.sv
// Queue occupancy counter: synchronises and debounces the entry (back) and
// exit (front) photocells, detects complete passages on beam restore and
// keeps a saturating customer count with full/empty flags and event pulses.
module queue_people_counter #(
    parameter int CNT_W      = 3,
    parameter int MAX_COUNT  = 7,
    parameter int DEB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    queue_people_counter_if.slave bus
);
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);

    localparam logic [0:0] ST_CLEAR   = 1'b0;
    localparam logic [0:0] ST_BLOCKED = 1'b1;

    // Index 0 = back (entry) beam, index 1 = front (exit) beam.
    logic [1:0]     raw;
    logic [1:0]     sync_p0;
    logic [1:0]     sync_p1;
    logic [1:0]     filt;
    logic [DCW-1:0] deb_cnt [2];
    logic [0:0]     state_q [2];
    logic [1:0]     vld_p0;

    logic [CNT_W-1:0] pcount_p1;
    logic             enter_p1;
    logic             leave_p1;
    logic             ovf_p1;
    logic             unf_p1;

    logic [CNT_W-1:0] cnt_nx;
    logic             enter_nx;
    logic             leave_nx;
    logic             ovf_nx;
    logic             unf_nx;

    // Saturating step helpers keep the count inside 0..MAX_COUNT.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? '0 : c - CNT_W'(1);
    endfunction

    assign raw = {bus.front_sensor, bus.back_sensor};

    // --- stage p0/p1: two-flop synchroniser, then per-beam debounce filter ---
    // Filtered level toggles only after DEB_CYCLES consecutive disagreeing edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            filt    <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == filt[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    filt[i]    <= ~filt[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DCW'(1);
                end
            end
        end
    end

    // Passage tracker: a beam must break and then restore to count as a passage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) state_q[i] <= ST_CLEAR;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state_q[i] == ST_CLEAR && filt[i])
                    state_q[i] <= ST_BLOCKED;
                else if (state_q[i] == ST_BLOCKED && !filt[i])
                    state_q[i] <= ST_CLEAR;
            end
        end
    end

    // Passage request is live for the single cycle between filt fall and the tracker catching up.
    always_comb begin
        for (int i = 0; i < 2; i++) vld_p0[i] = (state_q[i] == ST_BLOCKED) && !filt[i];
    end

    // Occupancy rules; a simultaneous entry+exit on an empty queue admits the entrant.
    always_comb begin
        cnt_nx   = pcount_p1;
        enter_nx = 1'b0;
        leave_nx = 1'b0;
        ovf_nx   = 1'b0;
        unf_nx   = 1'b0;
        case (vld_p0)
            2'b01: begin
                if (pcount_p1 == CNT_MAX) begin
                    ovf_nx = 1'b1;
                end else begin
                    cnt_nx   = sat_inc(pcount_p1);
                    enter_nx = 1'b1;
                end
            end
            2'b10: begin
                if (pcount_p1 == '0) begin
                    unf_nx = 1'b1;
                end else begin
                    cnt_nx   = sat_dec(pcount_p1);
                    leave_nx = 1'b1;
                end
            end
            2'b11: begin
                enter_nx = 1'b1;
                if (pcount_p1 == '0) begin
                    cnt_nx = sat_inc(pcount_p1);
                    unf_nx = 1'b1;
                end else begin
                    leave_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // --- stage p1: registered count and one-cycle event/error pulses ---
    always_ff @(posedge clk) begin
        if (rst) begin
            pcount_p1 <= '0;
            enter_p1  <= 1'b0;
            leave_p1  <= 1'b0;
            ovf_p1    <= 1'b0;
            unf_p1    <= 1'b0;
        end else begin
            pcount_p1 <= cnt_nx;
            enter_p1  <= enter_nx;
            leave_p1  <= leave_nx;
            ovf_p1    <= ovf_nx;
            unf_p1    <= unf_nx;
        end
    end

    assign bus.Pcount        = pcount_p1;
    assign bus.full          = (pcount_p1 == CNT_MAX);
    assign bus.empty         = (pcount_p1 == '0);
    assign bus.enter_evt     = enter_p1;
    assign bus.leave_evt     = leave_p1;
    assign bus.overflow_err  = ovf_p1;
    assign bus.underflow_err = unf_p1;
endmodule

// File: tb/tb_queue_people_counter.sv
// Scoreboard bench for queue_people_counter: stimulus pushes the expected
// outcome of each passage, a negedge monitor pops and compares on any pulse.
module tb_queue_people_counter;
    localparam int CNT_W  = 3;
    localparam int MAXC   = 7;
    localparam int DEB    = 4;
    localparam int LAT    = DEB + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   mcnt = 0;

    typedef struct {
        int edge_n;
        bit ent;
        bit lv;
        bit ovf;
        bit unf;
        int cnt;
    } exp_t;

    exp_t sbq[$];

    queue_people_counter_if #(.CNT_W(CNT_W)) bus ();

    queue_people_counter #(
        .CNT_W(CNT_W),
        .MAX_COUNT(MAXC),
        .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain occupancy rules applied to the model count.
    function automatic void model_push(input bit e, input bit x, input int edge_n);
        exp_t r;
        r.edge_n = edge_n;
        r.ent = 0; r.lv = 0; r.ovf = 0; r.unf = 0;
        if (e && x) begin
            if (mcnt == 0) begin
                mcnt = 1; r.ent = 1; r.unf = 1;
            end else begin
                r.ent = 1; r.lv = 1;
            end
        end else if (e) begin
            if (mcnt == MAXC) r.ovf = 1;
            else begin mcnt = mcnt + 1; r.ent = 1; end
        end else if (x) begin
            if (mcnt == 0) r.unf = 1;
            else begin mcnt = mcnt - 1; r.lv = 1; end
        end
        r.cnt = mcnt;
        sbq.push_back(r);
    endfunction

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (bus.enter_evt || bus.leave_evt || bus.overflow_err || bus.underflow_err)) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got ent=%0b lv=%0b ovf=%0b unf=%0b expected none (edge %0d)",
                         bus.enter_evt, bus.leave_evt, bus.overflow_err, bus.underflow_err, cyc);
            end else begin
                e = sbq.pop_front();
                check("evt_edge",      cyc,                   e.edge_n);
                check("enter_evt",     int'(bus.enter_evt),     int'(e.ent));
                check("leave_evt",     int'(bus.leave_evt),     int'(e.lv));
                check("overflow_err",  int'(bus.overflow_err),  int'(e.ovf));
                check("underflow_err", int'(bus.underflow_err), int'(e.unf));
                check("Pcount",        int'(bus.Pcount),        e.cnt);
                check("full",          int'(bus.full),          int'(e.cnt == MAXC));
                check("empty",         int'(bus.empty),         int'(e.cnt == 0));
            end
        end
    end

    task automatic settle_check(input int gap);
        repeat (gap) @(negedge clk);
        check("missing_pulse", sbq.size(), 0);
        sbq.delete();
        check("idle_Pcount", int'(bus.Pcount), mcnt);
    endtask

    // Hold the chosen beams broken for 'hold' cycles, release together.
    task automatic passage(input bit b, input bit f, input int hold);
        @(negedge clk);
        bus.back_sensor  = b;
        bus.front_sensor = f;
        repeat (hold) @(negedge clk);
        bus.back_sensor  = 1'b0;
        bus.front_sensor = 1'b0;
        model_push(b, f, cyc + 1 + LAT);
        settle_check($urandom_range(10, 16));
    endtask

    // Short pulses on either beam that must never reach the filter.
    task automatic glitch(input int hb, input int hf);
        int m;
        m = (hb > hf) ? hb : hf;
        @(negedge clk);
        bus.back_sensor  = (hb > 0);
        bus.front_sensor = (hf > 0);
        for (int i = 1; i <= m; i++) begin
            @(negedge clk);
            if (i == hb) bus.back_sensor = 1'b0;
            if (i == hf) bus.front_sensor = 1'b0;
        end
        settle_check(14);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.back_sensor  = 1'b0;
        bus.front_sensor = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and idle
        check("rst_Pcount", int'(bus.Pcount), 0);
        check("rst_empty",  int'(bus.empty), 1);
        check("rst_full",   int'(bus.full), 0);
        for (int i = 0; i < 20; i++) begin
            check("idle_pulses", int'({bus.enter_evt, bus.leave_evt, bus.overflow_err, bus.underflow_err}), 0);
            @(negedge clk);
        end

        // Single entry, then glitches on both beams
        passage(1, 0, 10);
        glitch(3, 2);
        glitch(DEB - 1, 0);
        glitch(0, DEB - 1);

        // Fill to capacity, overflow once, then one exit
        for (int i = 0; i < 6; i++) passage(1, 0, $urandom_range(DEB, DEB + 6));
        check("cap_full", int'(bus.full), 1);
        passage(1, 0, 8);
        passage(0, 1, 8);
        check("after_exit_full", int'(bus.full), 0);

        // Simultaneous release at 3 and at 0, plus an underflow
        while (mcnt > 3) passage(0, 1, $urandom_range(DEB, DEB + 6));
        passage(1, 1, 9);
        while (mcnt > 0) passage(0, 1, $urandom_range(DEB, DEB + 6));
        passage(0, 1, 7);
        passage(1, 1, 7);

        // Randomised mix of passages and glitches
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0, 1: passage(1, 0, $urandom_range(DEB, DEB + 8));
                2:    passage(0, 1, $urandom_range(DEB, DEB + 8));
                3:    passage(1, 1, $urandom_range(DEB, DEB + 8));
                default: glitch($urandom_range(0, DEB - 1), $urandom_range(0, DEB - 1));
            endcase
        end

        // Reset mid-operation with the entry beam held through it
        while (mcnt < 5) passage(1, 0, $urandom_range(DEB, DEB + 4));
        while (mcnt > 5) passage(0, 1, $urandom_range(DEB, DEB + 4));
        @(negedge clk);
        bus.back_sensor = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mcnt = 0;
        check("midrst_Pcount", int'(bus.Pcount), 0);
        check("midrst_empty",  int'(bus.empty), 1);
        repeat (10) @(negedge clk);
        bus.back_sensor = 1'b0;
        model_push(1, 0, cyc + 1 + LAT);
        settle_check(14);
        check("post_rst_Pcount", int'(bus.Pcount), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/queue_people_counter.md
Name: queue_people_counter

Overview:
Upstream occupancy stage for the bank queue manager. Watches the back (entry) and front (exit-to-teller) photocell beams. Synchronises and debounces each beam and detects complete passages. Maintains a saturating customer count, Pcount, which drives the low address bits of the wait-time ROM, plus full/empty flags and error pulses for the display and alarm logic.

Parameters:
CNT_W, 3, width of Pcount; MAX_COUNT must be <= 2**CNT_W-1
MAX_COUNT, 7, queue capacity; full asserted at this value
DEB_CYCLES, 4, consecutive clock edges a synchronised beam level must differ from the filtered level before the filtered level toggles; legal range >= 1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
back_sensor  input  1  raw entry photocell, 1 = beam broken; asynchronous to clk
front_sensor  input  1  raw exit photocell, 1 = beam broken; asynchronous to clk
Pcount  output  CNT_W  current number of customers in queue
full  output  1  Pcount == MAX_COUNT
empty  output  1  Pcount == 0
enter_evt  output  1  one-cycle pulse, valid entry passage detected
leave_evt  output  1  one-cycle pulse, valid exit passage detected
overflow_err  output  1  one-cycle pulse, entry rejected because queue full
underflow_err  output  1  one-cycle pulse, exit rejected because queue empty

Behaviour:
- Reset (rst=1 at an edge): sync flops, filtered levels, debounce counters, event pulses and error pulses go to 0; Pcount=0; empty=1; full=0. Reset has priority over all other activity. A beam held broken through reset is seen as a new break after release and is counted when it clears.
- Synchroniser: each sensor passes through 2 flops. A raw change sampled at edge k appears on the synchronised signal s after edge k+1.
- Debounce, per sensor: counter increments on each edge where s != filt. It clears on any edge where s == filt. filt toggles, and the counter clears, on the DEB_CYCLES-th consecutive differing edge. A pulse or glitch shorter than DEB_CYCLES cycles after synchronisation never changes filt.
- Passage FSM, per sensor:
  - CLEAR (filt=0) -> BLOCKED on filt rise.
  - BLOCKED -> CLEAR on filt fall, raising the passage request.
  - A count happens only on beam restore (falling edge), so a customer standing in the beam is not counted.
- Count update: registered on the edge after the filt fall. Latency: raw fall first sampled at edge k -> Pcount/evt/err update at edge k+DEB_CYCLES+2 (k+6 with defaults).
- Update rules, evaluated against the current Pcount:
  - Entry only, not full: Pcount+1, enter_evt=1.
  - Entry only, full: Pcount unchanged, overflow_err=1, enter_evt=0.
  - Exit only, not empty: Pcount-1, leave_evt=1.
  - Exit only, empty: Pcount unchanged, underflow_err=1, leave_evt=0.
  - Both same cycle, 0 < Pcount: Pcount unchanged, enter_evt=1, leave_evt=1, no error. This includes the full case.
  - Both same cycle, Pcount==0: Pcount=1, enter_evt=1, underflow_err=1, leave_evt=0.
- Pcount never wraps; arithmetic is in CNT_W bits, clamped to 0..MAX_COUNT.
- full and empty are decoded directly from the Pcount register, so they change on the same edge as Pcount.
- All pulses are high for exactly one cycle per passage. The two sensors are fully independent.

Test Plan:
- Reset then idle: rst high 2 cycles, sensors 0 -> Pcount=0, empty=1, full=0, all pulses 0 for 20 cycles.
- Single entry: back_sensor high 10 cycles then low, first low sampled at edge k -> Pcount 0->1 and enter_evt=1 for one cycle at edge k+6; empty drops the same edge.
- Glitch rejection: back_sensor high 3 cycles then low, and front_sensor high 2 cycles -> no filt change, Pcount unchanged, no pulses.
- Fill to capacity: 8 clean entries -> Pcount steps 1..7, full=1 after the 7th entry; the 8th entry gives overflow_err=1 and Pcount stays 7. Then 1 exit -> Pcount=6, full=0.
- Simultaneous: at Pcount=3, both beams released on the same edge -> Pcount=3, enter_evt=leave_evt=1. At Pcount=0, same stimulus -> Pcount=1, underflow_err=1.
- Reset mid-operation: Pcount=5 with back beam blocked, assert rst 1 cycle while the beam stays blocked, then release -> Pcount=0 right after reset, then 1 after the release latency.
